// File: rtl/asteroides_pkg.sv
// Shared definitions for the asteroid memory writers: opcodes, spawner
// state encodings and the random-source constants.
package asteroides_pkg;

    localparam logic [1:0] OP_HOR_CRES = 2'b00;
    localparam logic [1:0] OP_HOR_DECR = 2'b01;
    localparam logic [1:0] OP_VER_CRES = 2'b10;
    localparam logic [1:0] OP_VER_DECR = 2'b11;

    typedef enum logic [3:0] {
        ST_INICIO              = 4'd0,
        ST_ESPERA              = 4'd1,
        ST_RESETA_CONTADOR     = 4'd2,
        ST_VERIFICA_LOADED     = 4'd3,
        ST_INCREMENTA_CONTADOR = 4'd4,
        ST_AUX                 = 4'd5,
        ST_ESCREVE             = 4'd6,
        ST_SINALIZA            = 4'd7,
        ST_CHEIO               = 4'd8
    } gera_estado_t;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/gera_asteroides_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; exposes only the low OUT_W bits
// so callers never carry unused random bits.
module lfsr_aste
    import asteroides_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic [OUT_W-1:0] rnd
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/gera_asteroides.sv
// Asteroid spawner: finds the first unloaded slot and writes a new asteroid
// entering from the border opposite its direction of travel.
module gera_asteroides
    import asteroides_pkg::*;
#(
    parameter int N_ASTE  = 16,
    parameter int ADDR_W  = 4,
    parameter int COORD_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               gera_aste,
    input  logic               loaded_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COORD_W-1:0] mem_wr_x,
    output logic [COORD_W-1:0] mem_wr_y,
    output logic [1:0]         mem_wr_opcode,
    output logic               mem_wr_loaded,
    output logic               geracao_concluida,
    output logic               sem_espaco,
    output logic [3:0]         db_estado_gera_aste
);

    localparam logic [COORD_W-1:0] MAX      = {COORD_W{1'b1}};
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(N_ASTE - 1);

    logic [COORD_W+1:0] rnd;

    lfsr_aste #(.OUT_W(COORD_W + 2)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .rnd   (rnd)
    );

    gera_estado_t       state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               we_q, concluida_q, sem_espaco_q;
    logic [COORD_W-1:0] r;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        r       = rnd[COORD_W+1:2];
        case (state_q)
            ST_INICIO: state_d = ST_ESPERA;
            ST_ESPERA: if (gera_aste) state_d = ST_RESETA_CONTADOR;
            ST_RESETA_CONTADOR: begin
                cnt_d   = '0;
                op_d    = rnd[1:0];
                state_d = ST_VERIFICA_LOADED;
                case (rnd[1:0])
                    OP_HOR_CRES: begin x_d = '0;  y_d = r;   end
                    OP_HOR_DECR: begin x_d = MAX; y_d = r;   end
                    OP_VER_CRES: begin x_d = r;   y_d = '0;  end
                    default:     begin x_d = r;   y_d = MAX; end
                endcase
            end
            ST_VERIFICA_LOADED: begin
                if (!loaded_rd)            state_d = ST_ESCREVE;
                else if (cnt_q == LAST_IDX) state_d = ST_CHEIO;
                else                        state_d = ST_INCREMENTA_CONTADOR;
            end
            ST_INCREMENTA_CONTADOR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_AUX;
            end
            ST_AUX:      state_d = ST_VERIFICA_LOADED;
            ST_ESCREVE:  state_d = ST_SINALIZA;
            ST_SINALIZA: state_d = ST_ESPERA;
            ST_CHEIO:    state_d = ST_ESPERA;
            default:     state_d = ST_INICIO;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INICIO;
            cnt_q        <= '0;
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            we_q         <= 1'b0;
            concluida_q  <= 1'b0;
            sem_espaco_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            we_q         <= (state_d == ST_ESCREVE);
            concluida_q  <= (state_d == ST_SINALIZA);
            sem_espaco_q <= (state_d == ST_CHEIO);
        end
    end

    always_comb begin
        case (state_q)
            ST_INICIO, ST_ESPERA, ST_RESETA_CONTADOR, ST_VERIFICA_LOADED,
            ST_INCREMENTA_CONTADOR, ST_AUX, ST_ESCREVE, ST_SINALIZA,
            ST_CHEIO: db_estado_gera_aste = state_q;
            default:  db_estado_gera_aste = 4'hF;
        endcase
    end

    assign mem_addr          = cnt_q;
    assign mem_we            = we_q;
    assign mem_wr_loaded     = we_q;
    assign mem_wr_x          = x_q;
    assign mem_wr_y          = y_q;
    assign mem_wr_opcode     = op_q;
    assign geracao_concluida = concluida_q;
    assign sem_espaco        = sem_espaco_q;

endmodule

// File: tb/tb_gera_asteroides.sv
// Directed bench for gera_asteroides against a slot-occupancy model and an
// independent LFSR model.
module tb_gera_asteroides;

    logic       clock = 1'b0;
    logic       reset, gera_aste, loaded_rd;
    logic [3:0] mem_addr, mem_wr_x, mem_wr_y, db_estado_gera_aste;
    logic [1:0] mem_wr_opcode;
    logic       mem_we, mem_wr_loaded, geracao_concluida, sem_espaco;

    gera_asteroides #(.N_ASTE(16), .ADDR_W(4), .COORD_W(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .gera_aste           (gera_aste),
        .loaded_rd           (loaded_rd),
        .mem_addr            (mem_addr),
        .mem_we              (mem_we),
        .mem_wr_x            (mem_wr_x),
        .mem_wr_y            (mem_wr_y),
        .mem_wr_opcode       (mem_wr_opcode),
        .mem_wr_loaded       (mem_wr_loaded),
        .geracao_concluida   (geracao_concluida),
        .sem_espaco          (sem_espaco),
        .db_estado_gera_aste (db_estado_gera_aste)
    );

    always #5 clock = ~clock;

    // Slot memory: bench preload plus anything the DUT wrote since the last clear.
    logic [15:0] preload = '0;
    logic [15:0] written = '0;
    logic        clr_written = 1'b1;
    assign loaded_rd = preload[mem_addr] | written[mem_addr];
    always @(posedge clock) begin
        if (clr_written)                written <= '0;
        else if (mem_we && mem_wr_loaded) written[mem_addr] <= 1'b1;
    end

    // x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
    logic [7:0] lfsr_m;
    always @(posedge clock) begin
        if (reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of one scan
    int         we_cnt, we_cyc, conc_cnt, conc_cyc, sem_cnt, sem_cyc;
    logic [3:0] we_addr, we_x, we_y, db_last;
    logic [1:0] we_op;
    logic       we_ld;
    logic [7:0] cap_lfsr;

    task automatic scan(input logic [15:0] pre, input int ncyc, input int second_pulse);
        @(negedge clock);
        preload = pre; clr_written = 1'b1; gera_aste = 1'b1;
        we_cnt = 0; we_cyc = -1; conc_cnt = 0; conc_cyc = -1; sem_cnt = 0; sem_cyc = -1;
        we_addr = 'x; we_x = 'x; we_y = 'x; we_op = 'x; we_ld = 'x; cap_lfsr = 'x;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            clr_written = 1'b0;
            gera_aste = (c == second_pulse);
            if (db_estado_gera_aste == 4'd2) cap_lfsr = lfsr_m;
            if (mem_we) begin
                we_cnt++; we_cyc = c; we_addr = mem_addr; we_ld = mem_wr_loaded;
                we_op = mem_wr_opcode; we_x = mem_wr_x; we_y = mem_wr_y;
            end
            if (geracao_concluida) begin conc_cnt++; conc_cyc = c; end
            if (sem_espaco) begin sem_cnt++; sem_cyc = c; end
            db_last = db_estado_gera_aste;
        end
    endtask

    task automatic check_spawn(input string tag, input logic [7:0] l);
        logic [3:0] r, ex, ey;
        r = l[5:2];
        case (l[1:0])
            2'b00:   begin ex = 4'd0;  ey = r;     end
            2'b01:   begin ex = 4'd15; ey = r;     end
            2'b10:   begin ex = r;     ey = 4'd0;  end
            default: begin ex = r;     ey = 4'd15; end
        endcase
        check({tag, "_op"}, 32'(we_op), 32'(l[1:0]));
        check({tag, "_x"},  32'(we_x),  32'(ex));
        check({tag, "_y"},  32'(we_y),  32'(ey));
        check({tag, "_ld"}, 32'(we_ld), 32'd1);
    endtask

    initial begin
        int k;
        logic [15:0] pre;

        // Reset state
        reset = 1'b1; gera_aste = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_db", 32'(db_estado_gera_aste), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wdata", {20'd0, mem_wr_x, mem_wr_y, mem_wr_opcode, mem_wr_loaded, 1'b0}, 32'd0);
        check("rst_pulses", {30'd0, geracao_concluida, sem_espaco}, 32'd0);

        // First spawn: LFSR A5 -> 4A -> 95 at reseta_contador, so opcode 01, x=15, y=5.
        reset = 1'b0; gera_aste = 1'b1; clr_written = 1'b0;
        @(negedge clock);
        check("t1_c0_espera", 32'(db_estado_gera_aste), 32'd1);
        @(negedge clock); gera_aste = 1'b0;
        check("t1_c1_reseta", 32'(db_estado_gera_aste), 32'd2);
        check("t1_c1_we", 32'(mem_we), 32'd0);
        @(negedge clock);
        check("t1_c2_verifica", 32'(db_estado_gera_aste), 32'd3);
        @(negedge clock);
        check("t1_c3_we", 32'(mem_we), 32'd1);
        check("t1_c3_addr", 32'(mem_addr), 32'd0);
        check("t1_c3_ld", 32'(mem_wr_loaded), 32'd1);
        check("t1_c3_op", 32'(mem_wr_opcode), 32'd1);
        check("t1_c3_x", 32'(mem_wr_x), 32'd15);
        check("t1_c3_y", 32'(mem_wr_y), 32'd5);
        @(negedge clock);
        check("t1_c4_conc", 32'(geracao_concluida), 32'd1);
        check("t1_c4_we", 32'(mem_we), 32'd0);
        @(negedge clock);
        check("t1_c5_espera", 32'(db_estado_gera_aste), 32'd1);
        check("t1_c5_conc", 32'(geracao_concluida), 32'd0);

        // Slots 0-2 loaded, slot 3 free
        scan(16'h0007, 15, -1);
        check("t2_we_cnt", 32'(we_cnt), 32'd1);
        check("t2_we_cyc", 32'(we_cyc), 32'd12);
        check("t2_we_addr", 32'(we_addr), 32'd3);
        check("t2_conc_cyc", 32'(conc_cyc), 32'd13);
        check("t2_db_end", 32'(db_last), 32'd1);
        check_spawn("t2", cap_lfsr);

        // Memory full
        scan(16'hFFFF, 49, -1);
        check("t3_sem_cnt", 32'(sem_cnt), 32'd1);
        check("t3_sem_cyc", 32'(sem_cyc), 32'd48);
        check("t3_we_cnt", 32'(we_cnt), 32'd0);
        check("t3_conc_cnt", 32'(conc_cnt), 32'd0);
        check("t3_db_c49", 32'(db_last), 32'd1);

        // Second request mid-scan is ignored
        scan(16'h0000, 12, 2);
        check("t5_conc_cnt", 32'(conc_cnt), 32'd1);
        check("t5_we_cnt", 32'(we_cnt), 32'd1);
        check("t5_db_end", 32'(db_last), 32'd1);

        // 200 requests against random occupancy
        for (int i = 0; i < 200; i++) begin
            pre = (i % 20 == 19) ? 16'hFFFF : 16'($urandom | $urandom);
            k = -1;
            for (int s = 15; s >= 0; s--) if (!pre[s]) k = s;
            scan(pre, 52, -1);
            check("t4_db_end", 32'(db_last), 32'd1);
            if (k < 0) begin
                check("t4_full_sem_cyc", 32'(sem_cyc), 32'd48);
                check("t4_full_we_cnt", 32'(we_cnt), 32'd0);
            end else begin
                check("t4_we_cnt", 32'(we_cnt), 32'd1);
                check("t4_we_cyc", 32'(we_cyc), 32'(3 + 3 * k));
                check("t4_we_addr", 32'(we_addr), 32'(k));
                check("t4_conc_cyc", 32'(conc_cyc), 32'(4 + 3 * k));
                check("t4_sem_cnt", 32'(sem_cnt), 32'd0);
                check_spawn("t4", cap_lfsr);
            end
        end

        // Reset in cycle 5 with slots 0-3 loaded
        @(negedge clock);
        preload = 16'h000F; clr_written = 1'b1; gera_aste = 1'b1; we_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            clr_written = 1'b0; gera_aste = 1'b0;
            if (mem_we) we_cnt++;
            if (c == 5) begin
                check("t6_c5_verifica", 32'(db_estado_gera_aste), 32'd3);
                check("t6_c5_addr", 32'(mem_addr), 32'd1);
                reset = 1'b1;
            end
            if (c == 6) begin
                check("t6_c6_db", 32'(db_estado_gera_aste), 32'd0);
                check("t6_c6_addr", 32'(mem_addr), 32'd0);
                reset = 1'b0;
            end
            if (c == 7) check("t6_c7_espera", 32'(db_estado_gera_aste), 32'd1);
        end
        check("t6_we_cnt", 32'(we_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gera_asteroides.md
# gera_asteroides

Asteroid spawner: the writer side of the asteroid memory, complementing the movement unit that scans it. On a spawn request it scans the asteroid memory for the first slot with `loaded = 0`. It then writes a new asteroid into that slot: pseudo-random opcode, entry position on the border opposite its direction of travel, and `loaded = 1`. It sits beside the movement unit on the same memory port, and the top-level game FSM sequences the two so they never run at once.

## Interface
Parameters:
- `N_ASTE`, 16: number of asteroid slots; must be a power of two.
- `ADDR_W`, 4: log2(N_ASTE).
- `COORD_W`, 4: width of each coordinate, 1..6. `MAX = 2^COORD_W - 1`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `gera_aste` in 1: spawn request, sampled only in `espera`.
- `loaded_rd` in 1: `loaded` bit of slot `mem_addr`; asynchronous memory read.
- `mem_addr` out ADDR_W: slot address, equal to the slot counter.
- `mem_we` out 1: one-cycle write strobe.
- `mem_wr_x`, `mem_wr_y` out COORD_W: spawn position.
- `mem_wr_opcode` out 2: direction of travel. 00 = x+, 01 = x−, 10 = y+, 11 = y−.
- `mem_wr_loaded` out 1: constant 1 during a write, 0 otherwise.
- `geracao_concluida` out 1: one-cycle pulse after a successful write.
- `sem_espaco` out 1: one-cycle pulse when all slots are occupied.
- `db_estado_gera_aste` out 4: current state code.

## Operation
- FSM, Moore outputs. Codes:
  - `inicio` = 0
  - `espera` = 1
  - `reseta_contador` = 2
  - `verifica_loaded` = 3
  - `incrementa_contador` = 4
  - `aux` = 5
  - `escreve` = 6
  - `sinaliza` = 7
  - `cheio` = 8
  - Any illegal code displays 4'hF and goes to `inicio`.
- Transitions:
  - `inicio` → `espera`.
  - `espera` → `reseta_contador` if `gera_aste`, else stay.
  - `reseta_contador` → `verifica_loaded`. Clears the counter and latches the spawn data.
  - `verifica_loaded`:
    - `!loaded_rd` → `escreve`.
    - `loaded_rd` and counter == N_ASTE−1 → `cheio`.
    - Otherwise → `incrementa_contador`.
  - `incrementa_contador` → `aux` → `verifica_loaded`. The counter increments on leaving `incrementa_contador`; `aux` is a read-settle cycle.
  - `escreve` → `sinaliza` → `espera`.
  - `cheio` → `espera`.
- Output assertion:
  - `mem_we` and `mem_wr_loaded` only in `escreve`.
  - `geracao_concluida` only in `sinaliza`.
  - `sem_espaco` only in `cheio`.
- Random source: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - Seed 8'hA5 on reset.
  - Advances every cycle, free-running; it is never zero.
- Spawn data is latched in `reseta_contador` from the LFSR value of that cycle, `r = lfsr[COORD_W+1:2]`:
  - `mem_wr_opcode = lfsr[1:0]`.
  - opcode 00: x = 0, y = r.
  - opcode 01: x = MAX, y = r.
  - opcode 10: x = r, y = 0.
  - opcode 11: x = r, y = MAX.
- Write data holds stable from the latch until the next `reseta_contador`.
- Counter is ADDR_W bits and saturates by FSM control; it never wraps during a scan.
- `gera_aste` outside `espera` is ignored; there is no queueing. If `gera_aste` is held high, the block re-triggers one cycle after `sinaliza` or `cheio`.
- Reset mid-operation: the next edge goes to `inicio`. A write is single-cycle, so no partial write is possible. The counter clears.

## Timing
- Reset values:
  - State `inicio`; `db_estado_gera_aste` = 0.
  - `mem_addr` = 0; `mem_we` = 0.
  - `mem_wr_x`, `mem_wr_y`, `mem_wr_opcode` = 0; `mem_wr_loaded` = 0.
  - `geracao_concluida` = 0; `sem_espaco` = 0.
  - LFSR = 8'hA5.
- Cycle 0 is the edge at which `espera` samples `gera_aste = 1`.
- First free slot k:
  - `mem_we` high in cycle 3+3k with `mem_addr = k`.
  - `geracao_concluida` high in cycle 4+3k.
  - Back in `espera` at cycle 5+3k.
- Memory full: `sem_espaco` high in cycle 3·N_ASTE (48 with the defaults), with no `mem_we`.
- `loaded_rd` must be valid in the same cycle `mem_addr` is presented in `verifica_loaded`.

## Structure
- Shared package `asteroides_pkg` holds:
  - Opcode constants `OP_HOR_CRES`, `OP_HOR_DECR`, `OP_VER_CRES`, `OP_VER_DECR`.
  - State encodings of this block.
  - LFSR seed (8'hA5) and tap constants.
- Sub-module `lfsr_aste`: 8-bit LFSR with synchronous reset to the seed.
- Top `gera_asteroides` contains the FSM, slot counter and spawn-data registers.

## Test plan
- Reset, all slots free, `gera_aste` pulse at cycle 0:
  - `mem_we` in cycle 3 with `mem_addr = 0` and `mem_wr_loaded = 1`.
  - `geracao_concluida` in cycle 4.
- Slots 0–2 loaded, slot 3 free:
  - `mem_we` only in cycle 12 with `mem_addr = 3`.
  - Exactly one write.
- All 16 slots loaded:
  - `sem_espaco` in cycle 48.
  - `mem_we` never asserted; `db_estado_gera_aste` returns to 1 at cycle 49.
- 200 requests against a memory model:
  - Every write obeys the border rule, e.g. opcode 00 → x = 0 and opcode 11 → y = 15.
  - Opcode and position match the bench LFSR model sampled at `reseta_contador`.
- Second `gera_aste` pulse at cycle 2 of a scan → exactly one `geracao_concluida`.
- Reset asserted in cycle 5 with slots 0–3 loaded:
  - `db_estado_gera_aste` = 0 on the next cycle.
  - `mem_addr` = 0 and `mem_we` never asserted.
